// File: rtl/load_store_controller_if.sv
// Execute-stage request, data-memory bus and writeback bundle
// for the load/store controller.
interface load_store_controller_if;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        req_ready;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_load_data;
  logic        wb_select_mem;
  logic        misaligned_fault;
  logic        timeout_fault;

  modport slave (
    input  req_valid, req_write, req_funct3,
    input  req_addr, req_wdata, req_rd,
    input  mem_rdata, mem_ack,
    output req_ready, stall,
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_byte_en,
    output wb_valid, wb_rd, wb_load_data,
    output wb_select_mem,
    output misaligned_fault, timeout_fault
  );

  modport master (
    output req_valid, req_write, req_funct3,
    output req_addr, req_wdata, req_rd,
    output mem_rdata, mem_ack,
    input  req_ready, stall,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_byte_en,
    input  wb_valid, wb_rd, wb_load_data,
    input  wb_select_mem,
    input  misaligned_fault, timeout_fault
  );
endinterface

// File: rtl/load_store_controller.sv
// RV32I load/store sequencer: memory handshake, lane steering,
// load extension and writeback mux select.
module load_store_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  load_store_controller_if.slave bus
);

  localparam int CntW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast =
    CntW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    Idle,
    Access,
    Respond
  } state_t;

  state_t          state;
  logic [CntW-1:0] waitCnt;
  logic            writeQ;
  logic [2:0]      funct3Q;
  logic [1:0]      offsetQ;
  logic [4:0]      rdQ;

  logic        isByte;
  logic        isHalf;
  logic        isWord;
  logic        illegal;
  logic        misaligned;
  logic [3:0]  laneEn;
  logic [31:0] laneData;

  logic [7:0]  rByte;
  logic [15:0] rHalf;
  logic        signBit;
  logic [31:0] loadExt;

  always_comb begin
    isByte = bus.req_funct3[1:0] == 2'b00;
    isHalf = bus.req_funct3[1:0] == 2'b01;
    isWord = bus.req_funct3[1:0] == 2'b10;
    if (bus.req_write)
      illegal = bus.req_funct3[2]
              | (bus.req_funct3[1:0] == 2'b11);
    else
      illegal = (bus.req_funct3[1:0] == 2'b11)
              | (bus.req_funct3[2] & bus.req_funct3[1]);
    misaligned = (isHalf & bus.req_addr[0])
               | (isWord & (|bus.req_addr[1:0]));
    laneEn   = 4'b0000;
    laneData = bus.req_wdata;
    unique case (1'b1)
      isByte: begin
        laneEn   = 4'b0001 << bus.req_addr[1:0];
        laneData = {4{bus.req_wdata[7:0]}};
      end
      isHalf: begin
        laneEn   = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        laneData = {2{bus.req_wdata[15:0]}};
      end
      isWord: begin
        laneEn   = 4'b1111;
        laneData = bus.req_wdata;
      end
      default: ;
    endcase
  end

  // Extract from the lane latched at accept time, not the live bus.
  always_comb begin
    unique case (offsetQ)
      2'd0:    rByte = bus.mem_rdata[7:0];
      2'd1:    rByte = bus.mem_rdata[15:8];
      2'd2:    rByte = bus.mem_rdata[23:16];
      default: rByte = bus.mem_rdata[31:24];
    endcase
    rHalf = offsetQ[1] ? bus.mem_rdata[31:16]
                       : bus.mem_rdata[15:0];
    signBit = 1'b0;
    loadExt = bus.mem_rdata;
    unique case (1'b1)
      funct3Q[1:0] == 2'b00: begin
        signBit = ~funct3Q[2] & rByte[7];
        loadExt = {{24{signBit}}, rByte};
      end
      funct3Q[1:0] == 2'b01: begin
        signBit = ~funct3Q[2] & rHalf[15];
        loadExt = {{16{signBit}}, rHalf};
      end
      default: ;
    endcase
  end

  assign bus.req_ready = state == Idle;
  assign bus.stall     = state != Idle;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= Idle;
      waitCnt              <= '0;
      writeQ               <= 1'b0;
      funct3Q              <= 3'b000;
      offsetQ              <= 2'b00;
      rdQ                  <= 5'd0;
      bus.mem_req          <= 1'b0;
      bus.mem_we           <= 1'b0;
      bus.mem_addr         <= 32'd0;
      bus.mem_wdata        <= 32'd0;
      bus.mem_byte_en      <= 4'b0000;
      bus.wb_valid         <= 1'b0;
      bus.wb_rd            <= 5'd0;
      bus.wb_load_data     <= 32'd0;
      bus.wb_select_mem    <= 1'b0;
      bus.misaligned_fault <= 1'b0;
      bus.timeout_fault    <= 1'b0;
    end else begin
      bus.misaligned_fault <= 1'b0;
      bus.timeout_fault    <= 1'b0;
      bus.wb_valid         <= 1'b0;
      bus.wb_select_mem    <= 1'b0;
      unique case (state)
        Idle: begin
          if (bus.req_valid) begin
            if (illegal | misaligned) begin
              bus.misaligned_fault <= 1'b1;
            end else begin
              writeQ          <= bus.req_write;
              funct3Q         <= bus.req_funct3;
              offsetQ         <= bus.req_addr[1:0];
              rdQ             <= bus.req_rd;
              waitCnt         <= '0;
              bus.mem_req     <= 1'b1;
              bus.mem_we      <= bus.req_write;
              bus.mem_addr    <= {bus.req_addr[31:2], 2'b00};
              bus.mem_wdata   <= laneData;
              bus.mem_byte_en <= laneEn;
              state           <= Access;
            end
          end
        end
        Access: begin
          // An ack in the last allowed cycle beats the timeout.
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            if (writeQ) begin
              state <= Idle;
            end else begin
              bus.wb_load_data  <= loadExt;
              bus.wb_rd         <= rdQ;
              bus.wb_valid      <= 1'b1;
              bus.wb_select_mem <= 1'b1;
              state             <= Respond;
            end
          end else if (waitCnt == CntLast) begin
            bus.mem_req       <= 1'b0;
            bus.timeout_fault <= 1'b1;
            state             <= Idle;
          end else begin
            waitCnt <= waitCnt + CntW'(1);
          end
        end
        Respond: begin
          state <= Idle;
        end
        default: begin
          state <= Idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_controller.sv
// Directed bench: transaction-level timeline model checked every
// cycle, plus literal expectations for the key vectors.
module tb_load_store_controller;

  localparam int MEM_TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   run = 1'b0;

  int checks = 0;
  int errors = 0;

  int reqCnt = 0;
  int wbvCnt = 0;
  int mfCnt  = 0;
  int tfCnt  = 0;
  logic [31:0] lastAddr;
  logic [3:0]  lastBe;
  logic [31:0] lastWd;
  logic        lastWe;
  logic [31:0] lastWb;

  typedef struct {
    logic        req;
    logic        ready;
    logic        wbv;
    logic        mf;
    logic        tf;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] wbd;
    logic [4:0]  rd;
  } exp_t;

  exp_t expQ[$];

  load_store_controller_if bus();

  load_store_controller #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] a,
                              logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endfunction

  function automatic exp_t idleRec();
    exp_t e;
    e = '{default: '0};
    e.ready = 1'b1;
    return e;
  endfunction

  function automatic int accSize(logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit modelBad(logic w, logic [2:0] f3,
                                  logic [31:0] a);
    bit ill;
    int sz;
    if (w) ill = f3 > 3'd2;
    else ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (ill) return 1'b1;
    sz = accSize(f3);
    return (int'(a[1:0]) % sz) != 0;
  endfunction

  function automatic logic [3:0] modelBe(logic [2:0] f3,
                                         logic [31:0] a);
    int sz = accSize(f3);
    int m = ((1 << sz) - 1) << int'(a[1:0]);
    return 4'(m);
  endfunction

  function automatic logic [31:0] modelWd(logic [2:0] f3,
                                          logic [31:0] wd);
    int sz = accSize(f3);
    logic [31:0] part;
    logic [31:0] r = '0;
    if (sz == 4) return wd;
    part = wd & ((32'd1 << (8 * sz)) - 32'd1);
    for (int i = 0; i < 4 / sz; i++)
      r = r | (part << (8 * sz * i));
    return r;
  endfunction

  function automatic logic [31:0] modelLoad(logic [2:0] f3,
                                            logic [31:0] a,
                                            logic [31:0] rdata);
    int bits = 8 * accSize(f3);
    logic [31:0] v;
    logic [31:0] m;
    if (bits == 32) return rdata;
    v = rdata >> (8 * int'(a[1:0]));
    m = (32'd1 << bits) - 32'd1;
    v = v & m;
    if (!f3[2] && v[bits-1]) v = v | ~m;
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (run) begin
      e = (expQ.size() > 0) ? expQ.pop_front() : idleRec();
      chk("mem_req", bus.mem_req, e.req);
      chk("req_ready", bus.req_ready, e.ready);
      chk("stall", bus.stall, !e.ready);
      chk("wb_valid", bus.wb_valid, e.wbv);
      chk("wb_select_mem", bus.wb_select_mem, e.wbv);
      chk("misaligned_fault", bus.misaligned_fault, e.mf);
      chk("timeout_fault", bus.timeout_fault, e.tf);
      if (e.req) begin
        chk("mem_addr", bus.mem_addr, e.addr);
        chk("mem_byte_en", bus.mem_byte_en, e.be);
        chk("mem_wdata", bus.mem_wdata, e.wd);
        chk("mem_we", bus.mem_we, e.we);
      end
      if (e.wbv) begin
        chk("wb_load_data", bus.wb_load_data, e.wbd);
        chk("wb_rd", bus.wb_rd, e.rd);
      end
      if (bus.mem_req) begin
        reqCnt++;
        lastAddr = bus.mem_addr;
        lastBe   = bus.mem_byte_en;
        lastWd   = bus.mem_wdata;
        lastWe   = bus.mem_we;
      end
      if (bus.wb_valid) begin
        wbvCnt++;
        lastWb = bus.wb_load_data;
      end
      if (bus.misaligned_fault) mfCnt++;
      if (bus.timeout_fault) tfCnt++;
    end
  end

  task automatic drain();
    int k = 0;
    while (expQ.size() > 0 && k < 64) begin
      @(posedge clk) #1;
      k++;
    end
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending expected 0",
               expQ.size());
      expQ.delete();
    end
    @(posedge clk) #1;
  endtask

  // d < 0 means memory never acknowledges.
  task automatic issue(input logic w, input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [4:0] rd,
                       input logic [31:0] rdata,
                       input int d);
    exp_t e;
    int n;
    reqCnt = 0;
    wbvCnt = 0;
    mfCnt  = 0;
    tfCnt  = 0;
    @(posedge clk) #1;
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_rd     = rd;
    bus.mem_rdata  = rdata;
    @(posedge clk) #1;
    bus.req_valid = 1'b0;
    if (modelBad(w, f3, a)) begin
      e = idleRec();
      e.mf = 1'b1;
      expQ.push_back(e);
    end else begin
      n = (d < 0) ? MEM_TIMEOUT : d + 1;
      e = idleRec();
      e.ready = 1'b0;
      e.req   = 1'b1;
      e.we    = w;
      e.addr  = {a[31:2], 2'b00};
      e.be    = modelBe(f3, a);
      e.wd    = modelWd(f3, wd);
      for (int i = 0; i < n; i++) expQ.push_back(e);
      if (d < 0) begin
        e = idleRec();
        e.tf = 1'b1;
        expQ.push_back(e);
      end else if (!w) begin
        e = idleRec();
        e.ready = 1'b0;
        e.wbv   = 1'b1;
        e.wbd   = modelLoad(f3, a, rdata);
        e.rd    = rd;
        expQ.push_back(e);
      end
      bus.mem_ack = (d == 0);
      for (int i = 1; i < n; i++) begin
        @(posedge clk) #1;
        bus.mem_ack = (i == d);
      end
      @(posedge clk) #1;
      bus.mem_ack = 1'b0;
    end
    drain();
  endtask

  task automatic chkResetOutputs(string tag);
    chk({tag, "_req"}, bus.mem_req, 1'b0);
    chk({tag, "_we"}, bus.mem_we, 1'b0);
    chk({tag, "_addr"}, bus.mem_addr, 32'd0);
    chk({tag, "_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_be"}, bus.mem_byte_en, 4'b0000);
    chk({tag, "_wbv"}, bus.wb_valid, 1'b0);
    chk({tag, "_wbrd"}, bus.wb_rd, 5'd0);
    chk({tag, "_wbdata"}, bus.wb_load_data, 32'd0);
    chk({tag, "_sel"}, bus.wb_select_mem, 1'b0);
    chk({tag, "_ready"}, bus.req_ready, 1'b1);
    chk({tag, "_stall"}, bus.stall, 1'b0);
    chk({tag, "_faults"},
        {bus.misaligned_fault, bus.timeout_fault}, 2'b00);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.req_rd     = 5'd0;
    bus.mem_rdata  = 32'd0;
    bus.mem_ack    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chkResetOutputs("reset");
    reset = 1'b0;
    run = 1'b1;

    // LB sign extension at 0x103
    issue(1'b0, 3'b000, 32'h103, 32'h0, 5'd5, 32'h80AABBCC, 0);
    chk("lb_data", lastWb, 32'hFFFFFF80);
    chk("lb_addr", lastAddr, 32'h100);
    chk("lb_be", lastBe, 4'b1000);
    chk("lb_wbv_count", wbvCnt, 1);

    issue(1'b0, 3'b101, 32'h202, 32'h0, 5'd6, 32'h80011234, 1);
    chk("lhu_data", lastWb, 32'h00008001);
    chk("lhu_req_cycles", reqCnt, 2);

    issue(1'b0, 3'b001, 32'h202, 32'h0, 5'd7, 32'h80011234, 0);
    chk("lh_data", lastWb, 32'hFFFF8001);
    chk("lh_be", lastBe, 4'b1100);

    issue(1'b0, 3'b100, 32'h101, 32'h0, 5'd0, 32'h80AABBCC, 2);
    chk("lbu_data", lastWb, 32'h000000BB);

    // SB lane steering
    issue(1'b1, 3'b000, 32'h301, 32'h000000A5, 5'd0, 32'h0, 0);
    chk("sb_wdata", lastWd, 32'hA5A5A5A5);
    chk("sb_be", lastBe, 4'b0010);
    chk("sb_we", lastWe, 1'b1);
    chk("sb_wbv_count", wbvCnt, 0);

    issue(1'b1, 3'b001, 32'h802, 32'h1234BEEF, 5'd0, 32'h0, 2);
    chk("sh_wdata", lastWd, 32'hBEEFBEEF);
    chk("sh_be", lastBe, 4'b1100);

    issue(1'b1, 3'b010, 32'h904, 32'hCAFEF00D, 5'd0, 32'h0, 1);
    chk("sw_wdata", lastWd, 32'hCAFEF00D);
    chk("sw_be", lastBe, 4'b1111);

    // Faults: misaligned word, illegal load and store funct3
    issue(1'b0, 3'b010, 32'h402, 32'h0, 5'd1, 32'h0, 0);
    chk("lw_mis_fault_count", mfCnt, 1);
    chk("lw_mis_req_count", reqCnt, 0);
    issue(1'b0, 3'b011, 32'h400, 32'h0, 5'd1, 32'h0, 0);
    chk("ld_ill_fault_count", mfCnt, 1);
    chk("ld_ill_req_count", reqCnt, 0);
    issue(1'b1, 3'b011, 32'h400, 32'h0, 5'd0, 32'h0, 0);
    chk("st_ill_fault_count", mfCnt, 1);
    issue(1'b0, 3'b001, 32'h203, 32'h0, 5'd1, 32'h0, 0);
    chk("lh_mis_fault_count", mfCnt, 1);

    // Timeout boundary
    issue(1'b1, 3'b010, 32'h600, 32'h11223344, 5'd0, 32'h0, -1);
    chk("to_req_cycles", reqCnt, 16);
    chk("to_fault_count", tfCnt, 1);
    issue(1'b0, 3'b010, 32'h700, 32'h0, 5'd9, 32'hDEADBEEF, 15);
    chk("ack16_fault_count", tfCnt, 0);
    chk("ack16_req_cycles", reqCnt, 16);
    chk("ack16_data", lastWb, 32'hDEADBEEF);

    // Loads to x0 still complete
    issue(1'b0, 3'b010, 32'h710, 32'h0, 5'd0, 32'h01020304, 0);
    chk("x0_wbv_count", wbvCnt, 1);

    // Reset in the middle of an access
    wbvCnt = 0;
    @(posedge clk) #1;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h500;
    bus.req_wdata  = 32'h0;
    bus.req_rd     = 5'd3;
    bus.mem_rdata  = 32'h12345678;
    @(posedge clk) #1;
    bus.req_valid = 1'b0;
    e = idleRec();
    e.ready = 1'b0;
    e.req   = 1'b1;
    e.addr  = 32'h500;
    e.be    = 4'b1111;
    e.wd    = 32'h0;
    for (int i = 0; i < 3; i++) expQ.push_back(e);
    @(posedge clk) #1;
    @(posedge clk) #1;
    reset = 1'b1;
    @(posedge clk) #1;
    reset = 1'b0;
    chkResetOutputs("midreset");
    bus.mem_ack = 1'b1;
    @(posedge clk) #1;
    bus.mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_wbv_count", wbvCnt, 0);

    // Normal operation resumes after the aborted access
    issue(1'b0, 3'b000, 32'h502, 32'h0, 5'd4, 32'h00FF0000, 0);
    chk("post_reset_lb", lastWb, 32'hFFFFFFFF);

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_controller.md
# load_store_controller

Sequences every RV32I load and store between the execute stage and data memory. It runs a request/acknowledge handshake with memory, steers byte lanes, and sign- or zero-extends load data. It also drives the select of the writeback data mux: select is 1 (memory data) only while a load result is presented, and 0 (ALU result) at all other times. The controller stalls the pipeline while an access is outstanding.

## Interface

Parameters:
- MEM_TIMEOUT, 16: maximum number of cycles mem_req is held without mem_ack before the access is aborted (minimum 2).

Ports (name, direction, width, meaning):
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  execute stage presents a memory operation; held until accepted.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign field. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  32  effective byte address.
- req_wdata  in  32  store data, right-justified.
- req_rd  in  5  load destination register.
- req_ready  out  1  controller accepts a request this cycle.
- stall  out  1  pipeline hold while an access is in flight.
- mem_req  out  1  memory access request.
- mem_we  out  1  write enable.
- mem_addr  out  32  word-aligned address.
- mem_wdata  out  32  lane-replicated store data.
- mem_byte_en  out  4  byte lane enables.
- mem_rdata  in  32  read data; valid when mem_ack is high.
- mem_ack  in  1  access complete.
- wb_valid  out  1  load result valid.
- wb_rd  out  5  load destination register.
- wb_load_data  out  32  extended load result.
- wb_select_mem  out  1  writeback mux select.
- misaligned_fault  out  1  one-cycle pulse: misaligned address or illegal funct3.
- timeout_fault  out  1  one-cycle pulse: memory did not acknowledge in time.

## Operation

State machine with three states: IDLE, ACCESS, RESPOND.

- **req_ready:** equals 1 only in IDLE.
- **stall:** equals 1 in ACCESS and RESPOND.

**IDLE, on req_valid:** the request is checked.
- Illegal funct3 faults: loads 011/11x; stores with funct3 other than 000/001/010.
- Misalignment faults:
  - halfword with addr[0] = 1;
  - word with addr[1:0] ≠ 00.
- On a fault: register misaligned_fault = 1 for the next cycle, start no memory access, remain in IDLE.
- Otherwise: latch all request fields, set the timeout counter to 0, and go to ACCESS.

**Lane steering:**
- mem_addr = {addr[31:2], 2'b00}.
- Byte access: mem_byte_en = 0001 << addr[1:0]; mem_wdata = wdata[7:0] replicated ×4.
- Halfword access: mem_byte_en = 0011 if addr[1] = 0, else 1100; mem_wdata = wdata[15:0] replicated ×2.
- Word access: mem_byte_en = 1111; mem_wdata = wdata.
- Loads use the same byte_en. mem_we = req_write.

**ACCESS:**
- mem_req = 1, with mem_addr, mem_we, mem_wdata and mem_byte_en held stable.
- On mem_ack, store: go to IDLE.
- On mem_ack, load: select the addressed byte or halfword of mem_rdata, sign-extend (LB/LH) or zero-extend (LBU/LHU) it, register the result into wb_load_data and wb_rd, and go to RESPOND.
- If mem_ack is absent for MEM_TIMEOUT consecutive ACCESS cycles: drop mem_req, pulse timeout_fault for one cycle, and go to IDLE.
- If mem_ack arrives in the final allowed cycle, the ack wins and no fault is raised.

**RESPOND:** wb_valid = 1 and wb_select_mem = 1 for exactly one cycle, then go to IDLE. Loads with rd = 0 still complete normally.

**Outside ACCESS:**
- mem_ack is ignored.
- mem_req, wb_valid and wb_select_mem are 0.

**Reset:**
- State is IDLE.
- mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en, wb_valid, wb_rd, wb_load_data, wb_select_mem and both faults are 0.
- req_ready = 1 and stall = 0.
- Reset in ACCESS or RESPOND aborts the operation: outputs take their reset values on the next edge, and any late mem_ack is ignored.

## Timing

- Cycle numbering: the request is accepted at edge N; mem_req rises in cycle N+1.
- Load with zero-wait ack (mem_ack in cycle N+1): wb_valid in cycle N+2; req_ready is high again in cycle N+3.
- Store with zero-wait ack: req_ready is high again in cycle N+2.
- Each wait cycle of mem_ack adds one cycle.
- A fault pulse appears in the cycle after the detecting edge.
- The timeout counter width is ceil(log2(MEM_TIMEOUT)).

## Test plan

- **LB sign extension:** LB at 0x103, mem_rdata = 0x80AABBCC, ack in the first ACCESS cycle → mem_addr = 0x100, mem_byte_en = 1000, wb_load_data = 0xFFFFFF80, wb_select_mem high for exactly one cycle, 3-cycle turnaround.
- **Halfword extension:** LHU at 0x202 with mem_rdata = 0x80011234 → 0x00008001; LH at the same address → 0xFFFF8001.
- **SB lane steering:** SB at 0x301 with wdata = 0x000000A5 → mem_we = 1, mem_byte_en = 0010, mem_wdata = 0xA5A5A5A5, wb_valid never asserted, req_ready high 2 cycles after acceptance.
- **Misaligned word:** LW at 0x402 → misaligned_fault pulses once, mem_req stays 0, req_ready stays 1; an illegal funct3 of 011 on a load behaves the same.
- **Timeout boundary:**
  - Case (a): no ack → mem_req high for exactly 16 cycles, then one timeout_fault pulse, then IDLE.
  - Case (b): ack in the 16th cycle → normal completion, no fault.
- **Reset mid-access:** assert reset during ACCESS with 3 wait cycles → all outputs at reset values on the next cycle; a subsequent mem_ack produces no wb_valid.
